// File: rtl/rd_ptr_grey_empty_if.sv
// rtl/rd_ptr_grey_empty_if.sv - read-side pointer/empty bundle between FIFO read logic and its user
interface rd_ptr_grey_empty_if #(
    parameter int pointer_width = 4
);
    logic                     rinc;
    logic [pointer_width-1:0] wptr_gray;
    logic [pointer_width-2:0] raddr;
    logic [pointer_width-1:0] rptr_gray;
    logic                     rempty;
    logic [pointer_width-1:0] rlevel;
    logic                     rerr;

    modport master (
        output rinc, wptr_gray,
        input  raddr, rptr_gray, rempty, rlevel, rerr
    );

    modport slave (
        input  rinc, wptr_gray,
        output raddr, rptr_gray, rempty, rlevel, rerr
    );
endinterface

// File: rtl/rd_ptr_grey_empty.sv
// rtl/rd_ptr_grey_empty.sv - async FIFO read pointer, write-pointer synchronizer and empty/level flags
module rd_ptr_grey_empty #(
    parameter int pointer_width = 4
) (
    input  logic                 rclk,
    input  logic                 rrst,
    rd_ptr_grey_empty_if.slave   bus
);
    localparam int pw = pointer_width;

    logic [pw-1:0] rbin;
    logic [pw-1:0] rgray;
    logic [pw-1:0] rq1_wptr;
    logic [pw-1:0] rq2_wptr;
    logic          rempty_q;
    logic [pw-1:0] rlevel_q;
    logic          rerr_q;

    logic          ren;
    logic [pw-1:0] rbin_next;
    logic [pw-1:0] rgray_next;
    logic [pw-1:0] wbin_sync;

    function automatic logic [pw-1:0] gray2bin(input logic [pw-1:0] g);
        logic [pw-1:0] b;
        b[pw-1] = g[pw-1];
        for (int i = pw - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        ren        = bus.rinc & ~rempty_q;
        rbin_next  = rbin + {{(pw-1){1'b0}}, ren};
        rgray_next = rbin_next ^ (rbin_next >> 1);
        wbin_sync  = gray2bin(rq2_wptr);
    end

    // Only rq2_wptr feeds logic; rq1_wptr exists purely to settle metastability.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin     <= '0;
            rgray    <= '0;
            rq1_wptr <= '0;
            rq2_wptr <= '0;
            rempty_q <= 1'b1;
            rlevel_q <= '0;
            rerr_q   <= 1'b0;
        end else begin
            rq1_wptr <= bus.wptr_gray;
            rq2_wptr <= rq1_wptr;
            rbin     <= rbin_next;
            rgray    <= rgray_next;
            rempty_q <= (rgray_next == rq2_wptr);
            rlevel_q <= wbin_sync - rbin_next;
            rerr_q   <= bus.rinc & rempty_q;
        end
    end

    assign bus.raddr     = rbin[pw-2:0];
    assign bus.rptr_gray = rgray;
    assign bus.rempty    = rempty_q;
    assign bus.rlevel    = rlevel_q;
    assign bus.rerr      = rerr_q;

    empty_matches_level: assert property (@(posedge rclk) disable iff (rrst)
        rempty_q == (rlevel_q == '0));
endmodule

// File: tb/tb_rd_ptr_grey_empty.sv
// tb/tb_rd_ptr_grey_empty.sv - table vectors plus random traffic against a count-based model
module tb_rd_ptr_grey_empty;
    logic rclk = 1'b0;
    logic rrst = 1'b1;

    rd_ptr_grey_empty_if #(.pointer_width(4)) bus ();

    rd_ptr_grey_empty #(.pointer_width(4)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus.slave)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        bit rst;
        bit inc;
        int w;
        bit e_empty;
        int e_level;
        int e_raddr;
        int e_gray;
        bit e_err;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model state: counts in plain binary, write count seen after two read edges
    int  m_rd, m_s1, m_s2, m_level;
    bit  m_empty, m_err;

    function automatic vec_t mk(bit rst, bit inc, int w, bit e, int l, int a, int g, bit err);
        vec_t v;
        v.rst = rst; v.inc = inc; v.w = w;
        v.e_empty = e; v.e_level = l; v.e_raddr = a; v.e_gray = g; v.e_err = err;
        return v;
    endfunction

    function automatic int gray_of(int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(bit rst, bit inc, int w);
        int seen;
        if (rst) begin
            m_rd = 0; m_s1 = 0; m_s2 = 0;
            m_empty = 1'b1; m_level = 0; m_err = 1'b0;
        end else begin
            seen  = m_s2;
            m_err = inc && m_empty;
            if (inc && !m_empty) m_rd = (m_rd + 1) % 16;
            m_empty = (seen == m_rd);
            m_level = (seen - m_rd + 16) % 16;
            m_s2 = m_s1;
            m_s1 = w % 16;
        end
    endtask

    task automatic step(bit rst, bit inc, int w);
        rrst          = rst;
        bus.rinc      = inc;
        bus.wptr_gray = 4'(gray_of(w % 16));
        @(posedge rclk);
        model_edge(rst, inc, w);
        #1;
    endtask

    initial begin
        int w;
        bus.rinc      = 1'b1;
        bus.wptr_gray = 4'b0011;

        // reset with rinc high and a nonzero write pointer
        vecs.push_back(mk(1, 1, 2, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 2, 1, 0, 0, 4'b0000, 0));
        // single word: visible after 3 edges, then one read
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 4'b0001, 0));
        // re-reset, then full drain of 8 words
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 8, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 8, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 8, 0, 8, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 8, 0, 7, 1, 4'b0001, 0));
        vecs.push_back(mk(0, 1, 8, 0, 6, 2, 4'b0011, 0));
        vecs.push_back(mk(0, 1, 8, 0, 5, 3, 4'b0010, 0));
        vecs.push_back(mk(0, 1, 8, 0, 4, 4, 4'b0110, 0));
        vecs.push_back(mk(0, 1, 8, 0, 3, 5, 4'b0111, 0));
        vecs.push_back(mk(0, 1, 8, 0, 2, 6, 4'b0101, 0));
        vecs.push_back(mk(0, 1, 8, 0, 1, 7, 4'b0100, 0));
        vecs.push_back(mk(0, 1, 8, 1, 0, 0, 4'b1100, 0));
        // wrap into the upper half of the pointer space
        vecs.push_back(mk(0, 0, 12, 1, 0, 0, 4'b1100, 0));
        vecs.push_back(mk(0, 0, 12, 1, 0, 0, 4'b1100, 0));
        vecs.push_back(mk(0, 0, 12, 0, 4, 0, 4'b1100, 0));
        vecs.push_back(mk(0, 1, 12, 0, 3, 1, 4'b1101, 0));
        vecs.push_back(mk(0, 1, 12, 0, 2, 2, 4'b1111, 0));
        vecs.push_back(mk(0, 1, 12, 0, 1, 3, 4'b1110, 0));
        vecs.push_back(mk(0, 1, 12, 1, 0, 4, 4'b1010, 0));
        // underflow: three reads while empty
        vecs.push_back(mk(0, 1, 12, 1, 0, 4, 4'b1010, 1));
        vecs.push_back(mk(0, 1, 12, 1, 0, 4, 4'b1010, 1));
        vecs.push_back(mk(0, 1, 12, 1, 0, 4, 4'b1010, 1));
        vecs.push_back(mk(0, 0, 12, 1, 0, 4, 4'b1010, 0));
        // 8 more writes (count 20 -> 4), three reads to level 5, then reset with rinc
        vecs.push_back(mk(0, 0, 4, 1, 0, 4, 4'b1010, 0));
        vecs.push_back(mk(0, 0, 4, 1, 0, 4, 4'b1010, 0));
        vecs.push_back(mk(0, 0, 4, 0, 8, 4, 4'b1010, 0));
        vecs.push_back(mk(0, 1, 4, 0, 7, 5, 4'b1011, 0));
        vecs.push_back(mk(0, 1, 4, 0, 6, 6, 4'b1001, 0));
        vecs.push_back(mk(0, 1, 4, 0, 5, 7, 4'b1000, 0));
        vecs.push_back(mk(1, 1, 4, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 4'b0000, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 4'b0000, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].inc, vecs[i].w);
            chk($sformatf("vec%0d rempty", i), 32'(bus.rempty),    32'(vecs[i].e_empty));
            chk($sformatf("vec%0d rlevel", i), 32'(bus.rlevel),    32'(vecs[i].e_level));
            chk($sformatf("vec%0d raddr", i),  32'(bus.raddr),     32'(vecs[i].e_raddr));
            chk($sformatf("vec%0d rptr_gray", i), 32'(bus.rptr_gray), 32'(vecs[i].e_gray));
            chk($sformatf("vec%0d rerr", i),   32'(bus.rerr),      32'(vecs[i].e_err));
        end

        // random traffic: writer never overruns the true read count
        step(1, 0, 0);
        w = 0;
        for (int c = 0; c < 600; c++) begin
            bit rst, inc;
            rst = ($urandom_range(0, 149) == 0);
            inc = ($urandom_range(0, 2) != 0);
            if (rst) w = 0;
            else if (((w - m_rd + 16) % 16) < 8 && $urandom_range(0, 1) == 1) w = (w + 1) % 16;
            step(rst, inc, w);
            chk("rnd rempty",    32'(bus.rempty),    32'(m_empty));
            chk("rnd rlevel",    32'(bus.rlevel),    32'(m_level));
            chk("rnd raddr",     32'(bus.raddr),     32'(m_rd % 8));
            chk("rnd rptr_gray", 32'(bus.rptr_gray), 32'(gray_of(m_rd)));
            chk("rnd rerr",      32'(bus.rerr),      32'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
